// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl
//   Runs one matrix-multiply pass on a ROWS x COLS systolic PE grid. The block
//   reads K operand slices from the A and B buffers, skews them diagonally
//   toward the grid, and watches the per-PE result valids. It signals either
//   completion or a timeout.
//
// Ports
//   i_CLK, i_RSTN         rising-edge clock, asynchronous active-low reset
//   i_START               pass request, honoured only while idle
//   o_BUSY                high whenever a pass is in flight
//   o_DONE / o_ERR        one-cycle pulses: pass complete / pass timed out
//   o_A_RADDR, o_A_REN    A buffer read port (data back one cycle later)
//   i_A_RDATA             A slice, one DBITS element per row
//   o_B_RADDR, o_B_REN    B buffer read port (data back one cycle later)
//   i_B_RDATA             B slice, one DBITS element per column
//   o_A, o_A_VALID        skewed row data and valids to the grid
//   o_B, o_B_VALID        skewed column data and valids to the grid
//   i_PE_VALID            result valids from the grid, one per PE
module systolic_array_ctrl #(
  parameter int DBITS = 8,
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int K     = 4,
  parameter int AW    = 2,
  parameter int TMO   = 64
) (
  input  logic                    i_CLK,
  input  logic                    i_RSTN,
  input  logic                    i_START,
  output logic                    o_BUSY,
  output logic                    o_DONE,
  output logic                    o_ERR,
  output logic [AW-1:0]           o_A_RADDR,
  output logic                    o_A_REN,
  input  logic [ROWS*DBITS-1:0]   i_A_RDATA,
  output logic [AW-1:0]           o_B_RADDR,
  output logic                    o_B_REN,
  input  logic [COLS*DBITS-1:0]   i_B_RDATA,
  output logic [ROWS*DBITS-1:0]   o_A,
  output logic [ROWS-1:0]         o_A_VALID,
  output logic [COLS*DBITS-1:0]   o_B,
  output logic [COLS-1:0]         o_B_VALID,
  input  logic [ROWS*COLS-1:0]    i_PE_VALID
);

  localparam int MAXRC = (ROWS > COLS) ? ROWS : COLS;
  localparam int DCW   = $clog2(MAXRC + 1);
  localparam int TCW   = $clog2(TMO + 1);
  localparam int NPE   = ROWS * COLS;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t         state_r;
  logic           busy_r;
  logic           done_r;
  logic           err_r;
  logic           ren_r;
  logic           rd_vld_r;
  logic [AW-1:0]  fetch_cnt_r;
  logic [DCW-1:0] drain_cnt_r;
  logic [TCW-1:0] tmo_cnt_r;
  logic [NPE-1:0] flags_r;

  // Pass sequencer; every control output is computed for the state being entered.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      ren_r       <= 1'b0;
      fetch_cnt_r <= '0;
      drain_cnt_r <= '0;
      tmo_cnt_r   <= '0;
      flags_r     <= '0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_START) begin
            state_r     <= ST_FETCH;
            busy_r      <= 1'b1;
            ren_r       <= 1'b1;
            fetch_cnt_r <= '0;
            drain_cnt_r <= '0;
            tmo_cnt_r   <= '0;
            flags_r     <= '0;
          end else begin
            busy_r <= 1'b0;
            ren_r  <= 1'b0;
          end
        end
        ST_FETCH: begin
          flags_r <= flags_r | i_PE_VALID;
          if (fetch_cnt_r == AW'(K - 1)) begin
            state_r <= ST_DRAIN;
            ren_r   <= 1'b0;
          end else begin
            fetch_cnt_r <= fetch_cnt_r + AW'(1);
          end
        end
        ST_DRAIN: begin
          flags_r <= flags_r | i_PE_VALID;
          // MAXRC+1 cycles: the longest chain plus the read-data register.
          if (drain_cnt_r == DCW'(MAXRC)) begin
            state_r <= ST_WAIT;
          end else begin
            drain_cnt_r <= drain_cnt_r + DCW'(1);
          end
        end
        ST_WAIT: begin
          flags_r <= flags_r | i_PE_VALID;
          // Completion is tested first so it wins over a coincident timeout.
          if (&flags_r) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else if (tmo_cnt_r == TCW'(TMO - 1)) begin
            state_r   <= ST_IDLE;
            err_r     <= 1'b1;
            busy_r    <= 1'b0;
            tmo_cnt_r <= TCW'(TMO);
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TCW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          ren_r   <= 1'b0;
        end
      endcase
    end
  end

  // Marks the cycle in which buffer read data is valid.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      rd_vld_r <= 1'b0;
    end else begin
      rd_vld_r <= ren_r;
    end
  end

  // Row r delays its lane by r+1 registers; newest stage sits at the LSB end.
  for (genvar r = 0; r < ROWS; r++) begin : g_a_row
    logic [(r+1)*DBITS-1:0] dat_r;
    logic [r:0]             vld_r;
    if (r == 0) begin : g_one
      // Single-stage chain for row 0.
      always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
          dat_r <= '0;
          vld_r <= '0;
        end else begin
          dat_r <= i_A_RDATA[0 +: DBITS];
          vld_r <= rd_vld_r;
        end
      end
    end else begin : g_many
      // Multi-stage chain for rows beyond 0.
      always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
          dat_r <= '0;
          vld_r <= '0;
        end else begin
          dat_r <= {dat_r[r*DBITS-1:0], i_A_RDATA[r*DBITS +: DBITS]};
          vld_r <= {vld_r[r-1:0], rd_vld_r};
        end
      end
    end
    assign o_A[r*DBITS +: DBITS] = dat_r[r*DBITS +: DBITS];
    assign o_A_VALID[r]          = vld_r[r];
  end

  // Column c delays its lane by c+1 registers, mirroring the row chains.
  for (genvar c = 0; c < COLS; c++) begin : g_b_col
    logic [(c+1)*DBITS-1:0] dat_r;
    logic [c:0]             vld_r;
    if (c == 0) begin : g_one
      // Single-stage chain for column 0.
      always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
          dat_r <= '0;
          vld_r <= '0;
        end else begin
          dat_r <= i_B_RDATA[0 +: DBITS];
          vld_r <= rd_vld_r;
        end
      end
    end else begin : g_many
      // Multi-stage chain for columns beyond 0.
      always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
          dat_r <= '0;
          vld_r <= '0;
        end else begin
          dat_r <= {dat_r[c*DBITS-1:0], i_B_RDATA[c*DBITS +: DBITS]};
          vld_r <= {vld_r[c-1:0], rd_vld_r};
        end
      end
    end
    assign o_B[c*DBITS +: DBITS] = dat_r[c*DBITS +: DBITS];
    assign o_B_VALID[c]          = vld_r[c];
  end

  assign o_BUSY    = busy_r;
  assign o_DONE    = done_r;
  assign o_ERR     = err_r;
  assign o_A_REN   = ren_r;
  assign o_B_REN   = ren_r;
  assign o_A_RADDR = fetch_cnt_r;
  assign o_B_RADDR = fetch_cnt_r;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl: a 2x2/K=2/TMO=8 instance covers the
// basic pass, ignored starts, reset mid-fetch, back-to-back and timeout; a
// 4x4/K=4 instance covers the skew of the outer lanes.
module tb_systolic_array_ctrl;

  logic        clk;
  logic        rst_n;

  logic        start, busy, done, err;
  logic [1:0]  a_raddr, b_raddr;
  logic        a_ren, b_ren;
  logic [15:0] a_rdata, b_rdata, a_dat, b_dat;
  logic [1:0]  a_vld, b_vld;
  logic [3:0]  pe_vld, pe_mask;

  logic        start4, busy4, done4, err4;
  logic [1:0]  a_raddr4, b_raddr4;
  logic        a_ren4, b_ren4;
  logic [31:0] a_rdata4, b_rdata4, a_dat4, b_dat4;
  logic [3:0]  a_vld4, b_vld4;
  logic [15:0] pe_vld4;

  logic [15:0] amem [0:3];
  logic [15:0] bmem [0:3];
  logic [31:0] amem4 [0:3];
  logic [31:0] bmem4 [0:3];

  int n_vec;
  int n_err;
  logic [1:0] ev;

  systolic_array_ctrl #(.DBITS(8), .ROWS(2), .COLS(2), .K(2), .AW(2), .TMO(8)) dut (
    .i_CLK(clk), .i_RSTN(rst_n), .i_START(start),
    .o_BUSY(busy), .o_DONE(done), .o_ERR(err),
    .o_A_RADDR(a_raddr), .o_A_REN(a_ren), .i_A_RDATA(a_rdata),
    .o_B_RADDR(b_raddr), .o_B_REN(b_ren), .i_B_RDATA(b_rdata),
    .o_A(a_dat), .o_A_VALID(a_vld), .o_B(b_dat), .o_B_VALID(b_vld),
    .i_PE_VALID(pe_vld)
  );

  systolic_array_ctrl #(.DBITS(8), .ROWS(4), .COLS(4), .K(4), .AW(2), .TMO(8)) dut4 (
    .i_CLK(clk), .i_RSTN(rst_n), .i_START(start4),
    .o_BUSY(busy4), .o_DONE(done4), .o_ERR(err4),
    .o_A_RADDR(a_raddr4), .o_A_REN(a_ren4), .i_A_RDATA(a_rdata4),
    .o_B_RADDR(b_raddr4), .o_B_REN(b_ren4), .i_B_RDATA(b_rdata4),
    .o_A(a_dat4), .o_A_VALID(a_vld4), .o_B(b_dat4), .o_B_VALID(b_vld4),
    .i_PE_VALID(pe_vld4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; buffers answer reads one cycle late, grid flags PE (r,c)
  // when row r and column c valids coincide.
  task automatic step();
    logic       ar, br, ar4, br4;
    logic [1:0] aa, ba, aa4, ba4;
    ar = a_ren;   aa = a_raddr;   br = b_ren;   ba = b_raddr;
    ar4 = a_ren4; aa4 = a_raddr4; br4 = b_ren4; ba4 = b_raddr4;
    @(posedge clk);
    #1;
    if (ar)  a_rdata  = amem[aa];
    if (br)  b_rdata  = bmem[ba];
    if (ar4) a_rdata4 = amem4[aa4];
    if (br4) b_rdata4 = bmem4[ba4];
    pe_vld = {a_vld[1] & b_vld[1], a_vld[1] & b_vld[0],
              a_vld[0] & b_vld[1], a_vld[0] & b_vld[0]} & pe_mask;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    start4 = 1'b0;
    a_rdata = 16'h0000;  b_rdata = 16'h0000;
    a_rdata4 = 32'h0;    b_rdata4 = 32'h0;
    pe_vld = 4'h0;
    pe_mask = 4'hF;
    pe_vld4 = 16'hFFFF;
    amem[0] = 16'h0201;  amem[1] = 16'h0403;  amem[2] = 16'h0000;  amem[3] = 16'h0000;
    bmem[0] = 16'h0605;  bmem[1] = 16'h0807;  bmem[2] = 16'h0000;  bmem[3] = 16'h0000;
    amem4[0] = 32'h01010101; amem4[1] = 32'h02020202; amem4[2] = 32'h03030303; amem4[3] = 32'h04040404;
    bmem4[0] = 32'h01010101; bmem4[1] = 32'h02020202; bmem4[2] = 32'h03030303; bmem4[3] = 32'h04040404;

    // Reset state
    step(); step();
    chk("rst_busy",  busy,    1'b0);
    chk("rst_done",  done,    1'b0);
    chk("rst_err",   err,     1'b0);
    chk("rst_ren",   {a_ren, b_ren}, 2'b00);
    chk("rst_addr",  {a_raddr, b_raddr}, 4'h0);
    chk("rst_a",     a_dat,   16'h0000);
    chk("rst_vld",   {a_vld, b_vld}, 4'h0);
    chk("rst_busy4", busy4,   1'b0);
    chk("rst_vld4",  {a_vld4, b_vld4}, 8'h00);
    rst_n = 1'b1;
    step(); step();

    // Basic pass, with ignored starts at S+1 (FETCH) and S+6 (DONE)
    start = 1'b1;
    step();
    for (int i = 0; i <= 8; i++) begin
      ev = (i == 2) ? 2'b01 : (i == 3) ? 2'b11 : (i == 4) ? 2'b10 : 2'b00;
      chk("basic_busy",  busy,  (i <= 6));
      chk("basic_done",  done,  (i == 6));
      chk("basic_err",   err,   1'b0);
      chk("basic_a_ren", a_ren, (i < 2));
      chk("basic_b_ren", b_ren, (i < 2));
      if (i < 2) begin
        chk("basic_a_raddr", a_raddr, i);
        chk("basic_b_raddr", b_raddr, i);
      end
      chk("basic_a_vld", a_vld, ev);
      chk("basic_b_vld", b_vld, ev);
      if (i == 2) begin
        chk("basic_a_s2", a_dat[7:0], 8'h01);
        chk("basic_b_s2", b_dat[7:0], 8'h05);
      end
      if (i == 3) begin
        chk("basic_a_s3", a_dat, 16'h0203);
        chk("basic_b_s3", b_dat, 16'h0607);
      end
      if (i == 4) begin
        chk("basic_a_s4", a_dat[15:8], 8'h04);
        chk("basic_b_s4", b_dat[15:8], 8'h08);
      end
      start = (i == 1 || i == 6);
      step();
    end
    start = 1'b0;

    // Reset mid-FETCH at S+1
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ren",  {a_ren, b_ren}, 2'b00);
    chk("mid_rst_addr", {a_raddr, b_raddr}, 4'h0);
    chk("mid_rst_dat",  {a_dat, b_dat}, 32'h0);
    chk("mid_rst_vld",  {a_vld, b_vld}, 4'h0);
    chk("mid_rst_pls",  {done, err}, 2'b00);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_ren",  a_ren, 1'b0);
      chk("post_rst_vld",  {a_vld, b_vld}, 4'h0);
      chk("post_rst_pls",  {done, err}, 2'b00);
    end

    // Clean pass after reset, then restart in the first IDLE cycle after DONE
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i <= 7; i++) begin
      chk("clean_busy", busy, (i <= 6));
      chk("clean_done", done, (i == 6));
      chk("clean_err",  err,  1'b0);
      if (i == 3) chk("clean_a_s3", a_dat, 16'h0203);
      if (i == 7) begin
        start = 1'b1;
        pe_mask = 4'b0111;
      end
      step();
    end
    start = 1'b0;

    // Second pass: PE 3 never reports, leftover flags must not complete it
    for (int j = 0; j <= 14; j++) begin
      chk("b2b_busy", busy, (j <= 12));
      chk("b2b_done", done, 1'b0);
      chk("b2b_err",  err,  (j == 13));
      chk("b2b_ren",  a_ren, (j < 2));
      if (j < 2) chk("b2b_raddr", a_raddr, j);
      step();
    end
    pe_mask = 4'hF;

    // Skew on the 4x4 instance: lane 0 at S+2..S+5, lane 3 at S+5..S+8
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int i = 0; i <= 11; i++) begin
      if (i >= 2 && i <= 5) begin
        chk("skew_a_lane0", a_dat4[7:0], i - 1);
        chk("skew_b_lane0", b_dat4[7:0], i - 1);
        chk("skew_a_vld0",  a_vld4[0], 1'b1);
      end
      if (i == 1 || i == 6) chk("skew_a_vld0_off", a_vld4[0], 1'b0);
      if (i >= 5 && i <= 8) begin
        chk("skew_a_lane3", a_dat4[31:24], i - 4);
        chk("skew_b_lane3", b_dat4[31:24], i - 4);
        chk("skew_a_vld3",  a_vld4[3], 1'b1);
        chk("skew_b_vld3",  b_vld4[3], 1'b1);
      end
      if (i == 4 || i == 9) chk("skew_a_vld3_off", a_vld4[3], 1'b0);
      chk("skew_ren4",  a_ren4, (i < 4));
      chk("skew_done4", done4, (i == 10));
      chk("skew_busy4", busy4, (i <= 10));
      chk("skew_err4",  err4,  1'b0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
